// File: rtl/core_pkg.sv
// Shared core types for the fetch/decode slice.
//   word_t      : one XLEN-bit machine word (pc or instruction)
//   fetch_pkt_t : {pc, instr} pair carried from fetch to decode
//   IBUF_DEPTH  : default instruction buffer depth
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned IBUF_DEPTH = 4;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_pkt_t;

endpackage

// File: rtl/instr_buffer.sv
// Fetch-to-decode instruction queue.
// A DEPTH-entry circular FIFO of {pc, instr} pairs. The pointers carry an
// extra wrap bit so that full and empty are told apart without a counter.
// A flush empties the queue in one cycle so that no wrong-path
// instructions reach decode.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   flush             discard every queued entry (branch redirect)
//   in_valid/in_ready fetch handshake; in_pc/in_instr is the offered pair
//   out_valid/out_ready decode handshake; out_pc/out_instr is the head
//   count             occupancy, 0..DEPTH
//   perf_full_cycles  (IBUF_PERF_EN only) cycles where fetch offered while full
//   perf_flushes      (IBUF_PERF_EN only) cycles with flush asserted
//
// Build option: define IBUF_PERF_EN to add the two saturating perf counters.
module instr_buffer
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = core_pkg::XLEN,
  parameter int unsigned DEPTH = core_pkg::IBUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count
`ifdef IBUF_PERF_EN
  ,
  output logic [31:0]              perf_full_cycles,
  output logic [31:0]              perf_flushes
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Same layout as fetch_pkt_t, sized by this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_idx, wr_idx;
  logic            empty, full, push, pop;

  assign rd_idx = rd_ptr_q[AW-1:0];
  assign wr_idx = wr_ptr_q[AW-1:0];

  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_idx == wr_idx) && (rd_ptr_q[AW] != wr_ptr_q[AW]);

  // in_ready depends only on state and flush, never on out_ready.
  assign in_ready  = !full && !flush;
  assign out_valid = !empty && !flush;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign out_pc    = mem_q[rd_idx].pc;
  assign out_instr = mem_q[rd_idx].instr;
  assign count     = wr_ptr_q - rd_ptr_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      // Emptying by catching the read pointer up keeps wr_ptr continuous.
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_idx] <= '{pc: in_pc, instr: in_instr};
    end
  end

`ifdef IBUF_PERF_EN
  logic [31:0] full_cyc_q, full_cyc_d;
  logic [31:0] flushes_q, flushes_d;

  always_comb begin
    full_cyc_d = full_cyc_q;
    flushes_d  = flushes_q;
    if (in_valid && full && (full_cyc_q != '1)) full_cyc_d = full_cyc_q + 32'd1;
    if (flush && (flushes_q != '1))             flushes_d  = flushes_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_cyc_q <= '0;
      flushes_q  <= '0;
    end else begin
      full_cyc_q <= full_cyc_d;
      flushes_q  <= flushes_d;
    end
  end

  assign perf_full_cycles = full_cyc_q;
  assign perf_flushes     = flushes_q;
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_instr_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_instr;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_instr;
  logic [2:0]  count;
`ifdef IBUF_PERF_EN
  logic [31:0] perf_full_cycles, perf_flushes;
`endif

  instr_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
`ifdef IBUF_PERF_EN
    ,
    .perf_full_cycles (perf_full_cycles),
    .perf_flushes     (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: ordered list of {pc, instr} pairs currently held.
  logic [63:0] model_q[$];
  int unsigned m_full_cycles = 0;
  int unsigned m_flushes     = 0;

  // Values sampled mid-cycle by the last step, for directed checks.
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_pc, s_out_instr;
  logic [2:0]  s_count;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs at the falling edge against
  // the model, then advance the model across the rising edge.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy);
    int unsigned occ;
    bit exp_rdy, exp_vld;
    reset = rst; flush = fl; in_valid = iv; in_pc = pc; in_instr = ins;
    out_ready = ordy;
    @(negedge clk);
    s_in_ready = in_ready; s_out_valid = out_valid;
    s_out_pc = out_pc; s_out_instr = out_instr; s_count = count;
    occ     = model_q.size();
    exp_rdy = (occ < DEPTH) && !fl;
    exp_vld = (occ > 0) && !fl;
    if (!rst) begin
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      check("out_valid", 64'(out_valid), 64'(exp_vld));
      check("count", 64'(count), 64'(occ));
      if (exp_vld) check("head", {out_pc, out_instr}, model_q[0]);
`ifdef IBUF_PERF_EN
      check("perf_full", 64'(perf_full_cycles), 64'(m_full_cycles));
      check("perf_flush", 64'(perf_flushes), 64'(m_flushes));
`endif
    end
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      m_full_cycles = 0;
      m_flushes     = 0;
    end else begin
      if (iv && occ == DEPTH) m_full_cycles++;
      if (fl) begin
        m_flushes++;
        model_q.delete();
      end else begin
        if (occ > 0 && ordy) void'(model_q.pop_front());
        if (iv && occ < DEPTH) model_q.push_back({pc, ins});
      end
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, '0, '0, ordy);
  endtask

  initial begin
    logic        hold;
    logic        iv, fl, rs, ordy;
    logic [31:0] pc, ins;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;

    // Reset then idle
    do_reset();
    idle(1'b0);
    check("rst_valid", 64'(s_out_valid), 64'd0);
    check("rst_count", 64'(s_count), 64'd0);
    check("rst_ready", 64'(s_in_ready), 64'd1);

    // Single push, visible one cycle later
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0050_0093, 1'b0);
    check("push_nobypass", 64'(s_out_valid), 64'd0);
    idle(1'b0);
    check("one_valid", 64'(s_out_valid), 64'd1);
    check("one_pc", 64'(s_out_pc), 64'h0);
    check("one_instr", 64'(s_out_instr), 64'h0050_0093);
    check("one_count", 64'(s_count), 64'd1);

    // Fill to DEPTH, hold a fifth offer, then drain in order
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 32'(4 * i), 32'h1000 + 32'(i), 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h10, 32'h1004, 1'b0);
    check("full_count", 64'(s_count), 64'd4);
    check("full_ready", 64'(s_in_ready), 64'd0);
    step(1'b0, 1'b0, 1'b1, 32'h10, 32'h1004, 1'b1);
    check("full_pop_ready", 64'(s_in_ready), 64'd0);
    check("drain_pc0", 64'(s_out_pc), 64'h0);
    step(1'b0, 1'b0, 1'b1, 32'h10, 32'h1004, 1'b0);
    check("retry_ready", 64'(s_in_ready), 64'd1);
    for (int i = 1; i < 5; i++) begin
      idle(1'b1);
      check("drain_pc", 64'(s_out_pc), 64'(4 * i));
    end
    idle(1'b0);
    check("drained_empty", 64'(s_out_valid), 64'd0);

    // Steady stream
    do_reset();
    step(1'b0, 1'b0, 1'b1, 32'h100, 32'hA0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1);
      check("stream_count", 64'(s_count), 64'd1);
      check("stream_pc", 64'(s_out_pc), 64'h100 + 64'(4 * (i - 1)));
    end

    // Flush with a concurrent offer
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h20 + 32'(4 * i), 32'h7, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h40, 32'h8, 1'b0);
    check("flush_ready", 64'(s_in_ready), 64'd0);
    check("flush_valid", 64'(s_out_valid), 64'd0);
    idle(1'b0);
    check("flush_count", 64'(s_count), 64'd0);
    step(1'b0, 1'b0, 1'b1, 32'h80, 32'h9, 1'b0);
    idle(1'b0);
    check("post_flush_pc", 64'(s_out_pc), 64'h80);

`ifdef IBUF_PERF_EN
    // Perf counters: 3 full-and-offered cycles, 2 flush pulses
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 32'(4 * i), 32'h1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h10, 32'h2, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    idle(1'b0);
    check("perf_full_3", 64'(perf_full_cycles), 64'd3);
    check("perf_flush_2", 64'(perf_flushes), 64'd2);
`endif

    // Randomized traffic; a refused offer is held stable until accepted
    do_reset();
    hold = 1'b0; pc = '0; ins = '0; iv = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        iv  = ($urandom_range(0, 99) < 65);
        pc  = pc + 32'd4;
        ins = $urandom;
      end
      fl   = ($urandom_range(0, 99) < 4);
      rs   = ($urandom_range(0, 999) < 3);
      ordy = ($urandom_range(0, 99) < 50);
      step(rs, fl, iv, pc, ins, ordy);
      hold = iv && !s_in_ready && !fl && !rs;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
